fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 63 ++++++
 tb/tb_fetch_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and the IF/ID register, with a run/pause/halt
// controller. Instruction memory is read combinationally at imem_addr.
module fetch_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        exec,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        running,
    output logic        halted
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]  state;
    logic [15:0] pc;
    logic        is_hlt;

    assign is_hlt    = (instr[15:14] == 2'b11) && (instr[7:4] == 4'hF);
    assign imem_addr = pc;
    assign running   = (state == RUN);
    assign halted    = (state == HALT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc       <= 16'h0000;
            instr    <= 16'h0000;
            instr_pc <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    // Entering RUN does not fetch; the first fetch is one edge later.
                    if (exec) state <= RUN;
                end
                RUN: begin
                    // A taken branch flushes the HLT sitting in IF/ID, so it is not a halt.
                    if (is_hlt && !pc_src) begin
                        state <= HALT;
                        instr <= 16'h0000;
                    end else if (exec) begin
                        state <= IDLE;
                    end else if (pc_src) begin
                        pc       <= branch_target;
                        instr    <= 16'h0000;
                        instr_pc <= 16'h0000;
                    end else if (!stall) begin
                        pc       <= pc + 16'd1;
                        instr    <= imem_data;
                        instr_pc <= pc;
                    end
                end
                default: ;  // HALT (and the unused encoding) hold until reset
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by randomized run/pause/stall/branch
// traffic, checked every cycle against a cycle-level behavioural model.
module tb_fetch_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        exec = 1'b0, stall = 1'b0, pc_src = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic [15:0] imem_addr, imem_data, instr, instr_pc;
    logic        running, halted;

    logic [15:0] mem [0:65535];
    int n_chk = 0, n_err = 0;

    // model: mode 0=idle, 1=run, 2=halt
    int          m_mode;
    logic [15:0] m_pc, m_instr, m_ipc;

    fetch_stage dut (
        .clock(clock), .reset(reset), .exec(exec), .stall(stall), .pc_src(pc_src),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_pc(instr_pc), .running(running), .halted(halted)
    );

    always #5 clock = ~clock;
    assign imem_data = mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hlt_word(input logic [15:0] w);
        return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = 16'h0; m_instr = 16'h0; m_ipc = 16'h0;
    endtask

    task automatic model_step();
        if (m_mode == 2) return;
        if (m_mode == 0) begin
            if (exec) m_mode = 1;
            return;
        end
        if (hlt_word(m_instr) && !pc_src) begin
            m_mode = 2; m_instr = 16'h0;
            return;
        end
        if (exec) begin
            m_mode = 0;
            return;
        end
        if (pc_src) begin
            m_pc = branch_target; m_instr = 16'h0; m_ipc = 16'h0;
        end else if (!stall) begin
            m_instr = mem[m_pc]; m_ipc = m_pc; m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".addr"},    {16'h0, imem_addr}, {16'h0, m_pc});
        chk({tag, ".instr"},   {16'h0, instr},     {16'h0, m_instr});
        chk({tag, ".ipc"},     {16'h0, instr_pc},  {16'h0, m_ipc});
        chk({tag, ".running"}, {31'h0, running},   {31'h0, m_mode == 1});
        chk({tag, ".halted"},  {31'h0, halted},    {31'h0, m_mode == 2});
    endtask

    // Entered and left at posedge+1; inputs are set by the caller beforehand.
    task automatic cycle(input string tag);
        model_step();
        @(posedge clock); #1;
        compare_all(tag);
    endtask

    // Asserts reset between edges and checks the effect before any clock edge.
    task automatic do_reset();
        exec = 0; stall = 0; pc_src = 0;
        #2 reset = 1'b0;
        #1 model_reset();
        compare_all("async_rst");
        @(negedge clock); #1 reset = 1'b1;
        model_step();
        @(posedge clock); #1;
        compare_all("rst_release");
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if (hlt_word(w)) w[15] = 1'b0;
            mem[a] = w;
        end
        mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003; mem[3] = 16'hC0F0;

        // reset state
        #3 model_reset();
        compare_all("reset");
        @(posedge clock); #1 reset = 1'b1;
        cycle("idle0");
        cycle("idle1");

        // basic fetch then halt
        exec = 1; cycle("start");
        chk("start.running", {31'h0, running}, 32'd1);
        exec = 0; cycle("f0");
        chk("f0.instr", {16'h0, instr}, 32'h1001); chk("f0.ipc", {16'h0, instr_pc}, 32'h0);
        cycle("f1");
        chk("f1.instr", {16'h0, instr}, 32'h1002); chk("f1.ipc", {16'h0, instr_pc}, 32'h1);
        cycle("f2");
        chk("f2.instr", {16'h0, instr}, 32'h1003); chk("f2.ipc", {16'h0, instr_pc}, 32'h2);
        chk("f2.addr", {16'h0, imem_addr}, 32'h3);
        cycle("hlt");
        chk("hlt.instr", {16'h0, instr}, 32'hC0F0);
        cycle("halt");
        chk("halt.halted", {31'h0, halted}, 32'd1); chk("halt.instr", {16'h0, instr}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            exec = 1'($urandom); stall = 1'($urandom); pc_src = 1'($urandom);
            branch_target = 16'($urandom);
            cycle("halt_hold");
            chk("halt_hold.pc", {16'h0, imem_addr}, 32'h4);
        end
        do_reset();

        // branch under stall
        exec = 1; cycle("run2");
        exec = 0; pc_src = 1; branch_target = 16'h0005; cycle("br5");
        stall = 1; branch_target = 16'h0040; cycle("br_stall");
        chk("br_stall.pc", {16'h0, imem_addr}, 32'h40); chk("br_stall.instr", {16'h0, instr}, 32'h0);
        stall = 0; pc_src = 0; cycle("br_fetch");
        chk("br_fetch.instr", {16'h0, instr}, {16'h0, mem[16'h40]});
        chk("br_fetch.ipc", {16'h0, instr_pc}, 32'h40);

        // wrap-around
        pc_src = 1; branch_target = 16'hFFFF; cycle("brFFFF");
        pc_src = 0; cycle("wrap");
        chk("wrap.ipc", {16'h0, instr_pc}, 32'hFFFF); chk("wrap.addr", {16'h0, imem_addr}, 32'h0);

        // pause / resume
        pc_src = 1; branch_target = 16'h0007; cycle("br7");
        pc_src = 0; exec = 1; cycle("pause");
        chk("pause.running", {31'h0, running}, 32'd0);
        exec = 0;
        for (int i = 0; i < 5; i++) begin
            cycle("paused");
            chk("paused.pc", {16'h0, imem_addr}, 32'h7);
        end
        exec = 1; cycle("resume");
        exec = 0; cycle("resume_fetch");
        chk("resume_fetch.ipc", {16'h0, instr_pc}, 32'h7);

        // async reset mid-run at PC=0x12
        pc_src = 1; branch_target = 16'h0012; cycle("br12");
        pc_src = 0; stall = 1; cycle("stall12");
        chk("stall12.pc", {16'h0, imem_addr}, 32'h12);
        do_reset();
        chk("rst.pc", {16'h0, imem_addr}, 32'h0); chk("rst.running", {31'h0, running}, 32'd0);

        // randomized traffic with a few HLT words planted
        for (int i = 0; i < 40; i++) mem[16'($urandom_range(0, 255))] = 16'hC3F5;
        for (int i = 0; i < 3000; i++) begin
            if (m_mode == 2 && $urandom_range(0, 7) == 0) begin
                do_reset();
                continue;
            end
            exec   = ($urandom_range(0, 15) == 0);
            stall  = ($urandom_range(0, 3) == 0);
            pc_src = ($urandom_range(0, 7) == 0);
            branch_target = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                cycle("rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
